// File: rtl/departure_light.sv
// Departure-side lock controller: qualifies the departure switch, requests the gate,
// times the transit and pulses dep_done. Optional transit blink on dep_li via DEP_BLINK_EN.
module departure_light #(
  parameter int QUAL_CYCLES    = 16,
  parameter int TRANSIT_CYCLES = 32,
  parameter int CNT_W          = 6
`ifdef DEP_BLINK_EN
  , parameter int BLINK_HALF   = 4
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic dep_sw,
  input  logic gate_open,
  input  logic level_ok,
  output logic dep_req,
  output logic dep_li,
  output logic dep_done,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUAL,
    S_REQ,
    S_TRANSIT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] QUAL_LOAD    = CNT_W'(QUAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRANSIT_LOAD = CNT_W'(TRANSIT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dep_req_q, dep_req_d;
  logic             dep_li_q, dep_li_d;
  logic             dep_done_q, dep_done_d;
  logic             busy_q, busy_d;
  logic             li_on_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= QUAL_LOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (dep_sw) state_d = S_QUAL;
      end
      S_QUAL: begin
        if (!dep_sw)           state_d = S_IDLE;
        else if (cnt_q == '0)  state_d = S_REQ;
        else                   cnt_d   = cnt_q - 1'b1;
      end
      S_REQ: begin
        // Withdrawal of the switch wins over a simultaneously ready gate.
        if (!dep_sw) begin
          state_d = S_IDLE;
        end else if (gate_open && level_ok) begin
          state_d = S_TRANSIT;
          cnt_d   = TRANSIT_LOAD;
        end
      end
      S_TRANSIT: begin
        if (!gate_open)        state_d = S_REQ;
        else if (cnt_q != '0)  cnt_d   = cnt_q - 1'b1;
        else if (!dep_sw)      state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Qualification always restarts from a full count whenever we land in IDLE.
    if (state_d == S_IDLE) cnt_d = QUAL_LOAD;
  end

`ifdef DEP_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  // Every entry into TRANSIT (including after a gate drop) restarts the blink high.
  always_comb begin
    blink_cnt_d = '0;
    blink_on_d  = 1'b1;
    if (state_d == S_TRANSIT && state_q == S_TRANSIT) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_on_d  = blink_on_q;
      end
    end
  end

  assign li_on_d = blink_on_d;
`else
  assign li_on_d = 1'b1;
`endif

  // Outputs are registered from the next state so they track the state register exactly.
  always_comb begin
    dep_req_d  = (state_d == S_REQ) || (state_d == S_TRANSIT);
    dep_li_d   = (state_d == S_REQ) || ((state_d == S_TRANSIT) && li_on_d);
    dep_done_d = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dep_req_q  <= 1'b0;
      dep_li_q   <= 1'b0;
      dep_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      dep_req_q  <= dep_req_d;
      dep_li_q   <= dep_li_d;
      dep_done_q <= dep_done_d;
      busy_q     <= busy_d;
    end
  end

  assign dep_req  = dep_req_q;
  assign dep_li   = dep_li_q;
  assign dep_done = dep_done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_departure_light.sv
// Bench for departure_light: directed timing checks, then randomized input runs
// compared every cycle against an elapsed-time reference model.
module tb_departure_light;

  localparam int QC = 16;
  localparam int TC = 32;
  localparam int BH = 4;

  logic clk = 1'b0;
  logic reset, dep_sw, gate_open, level_ok;
  logic dep_req, dep_li, dep_done, busy;

  departure_light dut (
    .clk       (clk),
    .reset     (reset),
    .dep_sw    (dep_sw),
    .gate_open (gate_open),
    .level_ok  (level_ok),
    .dep_req   (dep_req),
    .dep_li    (dep_li),
    .dep_done  (dep_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;

  // Reference model: phase plus time spent in the current phase.
  // 0 idle, 1 qualifying, 2 requesting, 3 in transit, 4 completion pulse
  int m_phase = 0;
  int m_age   = 0;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0b exp=%0b cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic g, input logic l);
    if (r) begin
      m_phase = 0;
      m_age   = 0;
    end else begin
      case (m_phase)
        0: if (s) begin m_phase = 1; m_age = 0; end
        1: begin
          if (!s)                  m_phase = 0;
          else if (m_age >= QC - 1) m_phase = 2;
          else                     m_age++;
        end
        2: begin
          if (!s)           m_phase = 0;
          else if (g && l) begin m_phase = 3; m_age = 0; end
        end
        3: begin
          if (!g)                            m_phase = 2;
          else if (m_age >= TC - 1 && !s)    m_phase = 4;
          else                               m_age++;
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  function automatic logic exp_li();
    if (m_phase == 2) return 1'b1;
`ifdef DEP_BLINK_EN
    if (m_phase == 3) return ((m_age / BH) % 2) == 0;
`else
    if (m_phase == 3) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Called at a falling edge: drive inputs, take one rising edge, check at the next falling edge.
  task automatic cycle(input logic r, input logic s, input logic g, input logic l);
    reset     = r;
    dep_sw    = s;
    gate_open = g;
    level_ok  = l;
    @(posedge clk);
    model_step(r, s, g, l);
    cyc++;
    @(negedge clk);
    check_eq("dep_req",  dep_req,  (m_phase == 2) || (m_phase == 3));
    check_eq("dep_li",   dep_li,   exp_li());
    check_eq("dep_done", dep_done, m_phase == 4);
    check_eq("busy",     busy,     m_phase != 0);
    if (dep_done) begin
      done_cnt++;
      $display("departure %0d complete at cycle %0d", done_cnt, cyc);
    end
  endtask

  int sw_left, gate_left, lvl_left;
  logic sw_v, gate_v, lvl_v, rst_v;

  initial begin
    reset = 1'b1; dep_sw = 1'b0; gate_open = 1'b0; level_ok = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Directed: switch high from edge 1, gate ready -> REQ at edge 17, TRANSIT at 18,
    // switch dropped during transit, completion at edge 18+32.
    for (int k = 1; k <= QC + TC + 4; k++) begin
      cycle(1'b0, k <= QC + 10, 1'b1, 1'b1);
      check_eq("dir_req",  dep_req,  (k >= QC + 1) && (k <= QC + 1 + TC));
      check_eq("dir_done", dep_done, k == QC + 2 + TC);
      check_eq("dir_busy", busy,     (k >= 1) && (k <= QC + 2 + TC));
    end

    // Directed: a single low sample restarts qualification.
    for (int k = 1; k <= 30; k++) begin
      cycle(1'b0, k != 11, 1'b0, 1'b0);
      check_eq("abort_req",  dep_req, k >= 12 + QC);
      check_eq("abort_busy", busy,    k != 11);
    end

    // Directed: reset mid-transit clears everything on the next cycle.
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("rst_req",  dep_req, 1'b0);
    check_eq("rst_busy", busy,    1'b0);

    // Randomized runs of held input levels.
    sw_left = 0; gate_left = 0; lvl_left = 0;
    sw_v = 1'b0; gate_v = 1'b1; lvl_v = 1'b1;
    for (int n = 0; n < 5000; n++) begin
      if (sw_left == 0) begin
        sw_v    = ($urandom_range(0, 9) < 7);
        sw_left = $urandom_range(1, 70);
      end
      if (gate_left == 0) begin
        gate_v    = ($urandom_range(0, 19) < 17);
        gate_left = $urandom_range(1, 70);
      end
      if (lvl_left == 0) begin
        lvl_v    = ($urandom_range(0, 9) < 8);
        lvl_left = $urandom_range(1, 20);
      end
      rst_v = ($urandom_range(0, 399) == 0);
      cycle(rst_v, sw_v, gate_v, lvl_v);
      sw_left--; gate_left--; lvl_left--;
    end

    check_eq("done_seen", done_cnt > 1, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
